freq_gen: RTL and testbench

FREQ_GEN -- requirements
Module: freq_gen

---
 rtl/freq_pkg.sv | 27 ++
 rtl/freq_gen_accum.sv | 55 +++++
 rtl/freq_gen.sv | 144 ++++++++++++++
 tb/tb_freq_gen.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/freq_pkg.sv
// Shared definitions for the freq_gen DDS clock generator: FSM encoding,
// default widths and a constant helper converting a target frequency to an fcw.
package freq_pkg;

  localparam int          ACC_W_DEFAULT       = 32'sd32;
  localparam int unsigned REFCLK_FREQ_DEFAULT = 32'd200000000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  // fcw = hz * 2^acc_w / refclk, truncated; a zero reference yields zero.
  function automatic longint unsigned hz_to_fcw(input longint unsigned hz,
                                                input longint unsigned refclk,
                                                input int              acc_w);
    longint unsigned result;
    if (refclk == 64'd0) begin
      result = 64'd0;
    end else begin
      result = (hz << acc_w) / refclk;
    end
    return result;
  endfunction

endpackage

// File: rtl/freq_gen_accum.sv
// Phase accumulator for freq_gen: acc register, carry-out (wrap) detect and
// the registered MSB that forms clk_out, plus the rising-edge pulse.
module freq_gen_accum
  import freq_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic             ref_clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             clr,
  input  logic [ACC_W-1:0] fcw,
  output logic             wrap,
  output logic             clk_out,
  output logic             clk_rise
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W:0]   sum;
  logic             out_next;
  logic             rise_next;

  // Next accumulator value, carry detect and next output levels.
  always_comb begin
    sum      = {1'b0, acc} + {1'b0, fcw};
    acc_next = acc;
    if (clr) begin
      acc_next = {ACC_W{1'b0}};
    end else if (adv) begin
      acc_next = sum[ACC_W-1:0];
    end else begin
      acc_next = acc;
    end
    wrap      = adv & sum[ACC_W];
    // When generation ends, an already-high phase is allowed to finish but a
    // new high pulse never starts, so clk_rise cannot fire outside RUN/STOPPING.
    out_next  = acc[ACC_W-1] & (clk_out | ~clr);
    rise_next = out_next & ~clk_out;
  end

  // Accumulator and output registers.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= {ACC_W{1'b0}};
      clk_out  <= 1'b0;
      clk_rise <= 1'b0;
    end else begin
      acc      <= acc_next;
      clk_out  <= out_next;
      clk_rise <= rise_next;
    end
  end

endmodule

// File: rtl/freq_gen.sv
// DDS square-wave generator: IDLE/RUN/STOPPING control, fcw valid/ready intake
// with glitch-free retuning on accumulator wrap. Option: FREQ_GEN_CYCLE_CNT_EN.
module freq_gen
  import freq_pkg::*;
#(
  parameter int unsigned REFCLK_FREQ = REFCLK_FREQ_DEFAULT,
  parameter int          ACC_W       = ACC_W_DEFAULT
) (
  input  logic             ref_clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [ACC_W-1:0] fcw,
  input  logic             fcw_valid,
  output logic             fcw_ready,
  output logic             clk_out,
  output logic             clk_rise,
  output logic             running
`ifdef FREQ_GEN_CYCLE_CNT_EN
  ,
  output logic [31:0]      cycle_count
`endif
);

  // An output at REFCLK_FREQ corresponds to full scale; half of it is Nyquist.
  localparam longint unsigned FULL_SCALE  = hz_to_fcw(64'(REFCLK_FREQ), 64'(REFCLK_FREQ), ACC_W);
  localparam logic [ACC_W-1:0] NYQUIST_FCW = ACC_W'(FULL_SCALE >> 1);

  state_t           state;
  state_t           state_next;
  logic [ACC_W-1:0] active_fcw;
  logic [ACC_W-1:0] pending_fcw;
  logic [ACC_W-1:0] fcw_clamped;
  logic             pending_valid;
  logic             accept;
  logic             apply;
  logic             adv;
  logic             clr;
  logic             wrap;

  // Next-state logic; a zero fcw never wraps, so STOPPING leaves at once.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_next = ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (enable) begin
          state_next = ST_RUN;
        end else begin
          state_next = ST_STOPPING;
        end
      end
      ST_STOPPING: begin
        if (enable) begin
          state_next = ST_RUN;
        end else if (wrap || (active_fcw == {ACC_W{1'b0}})) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_STOPPING;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Handshake, retune and accumulator control decode.
  always_comb begin
    accept = fcw_valid & fcw_ready;
    apply  = pending_valid & ((state == ST_IDLE) | wrap);
    adv    = (state == ST_RUN) | (state == ST_STOPPING);
    clr    = (state_next == ST_IDLE);
    if (fcw > NYQUIST_FCW) begin
      fcw_clamped = NYQUIST_FCW;
    end else begin
      fcw_clamped = fcw;
    end
  end

  // State register and the running flag that mirrors it.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_next;
      running <= (state_next != ST_IDLE);
    end
  end

  // fcw intake: accept into pending, promote to active in IDLE or on a wrap.
  // A value accepted on a wrap edge is not yet pending there, so it waits a wrap.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      active_fcw    <= {ACC_W{1'b0}};
      pending_fcw   <= {ACC_W{1'b0}};
      pending_valid <= 1'b0;
      fcw_ready     <= 1'b1;
    end else if (accept) begin
      pending_fcw   <= fcw_clamped;
      pending_valid <= 1'b1;
      fcw_ready     <= 1'b0;
    end else if (apply) begin
      active_fcw    <= pending_fcw;
      pending_valid <= 1'b0;
      fcw_ready     <= 1'b1;
    end else begin
      active_fcw    <= active_fcw;
      pending_valid <= pending_valid;
      fcw_ready     <= fcw_ready;
    end
  end

  freq_gen_accum #(
    .ACC_W(ACC_W)
  ) u_accum (
    .ref_clk (ref_clk),
    .rst_n   (rst_n),
    .adv     (adv),
    .clr     (clr),
    .fcw     (active_fcw),
    .wrap    (wrap),
    .clk_out (clk_out),
    .clk_rise(clk_rise)
  );

`ifdef FREQ_GEN_CYCLE_CNT_EN
  // Free-running count of output rising edges, wrapping modulo 2^32.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= 32'd0;
    end else begin
      cycle_count <= cycle_count + {31'd0, clk_rise};
    end
  end
`endif

endmodule

// File: tb/tb_freq_gen.sv
// Self-checking bench for freq_gen (ACC_W=8): directed scenarios plus random
// stimulus against a cycle-level phase model built from the frequency rules.
module tb_freq_gen;

  localparam int ACC_W = 8;
  localparam int FULL  = 256;
  localparam int HALF  = 128;

  logic             ref_clk   = 1'b0;
  logic             rst_n     = 1'b1;
  logic             enable    = 1'b0;
  logic             fcw_valid = 1'b0;
  logic [ACC_W-1:0] fcw       = 8'd0;
  logic             fcw_ready;
  logic             clk_out;
  logic             clk_rise;
  logic             running;
`ifdef FREQ_GEN_CYCLE_CNT_EN
  logic [31:0]      cycle_count;
  logic [31:0]      cnt_start;
`endif

  freq_gen #(
    .REFCLK_FREQ(32'd200000000),
    .ACC_W      (ACC_W)
  ) dut (
    .ref_clk    (ref_clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .fcw        (fcw),
    .fcw_valid  (fcw_valid),
    .fcw_ready  (fcw_ready),
    .clk_out    (clk_out),
    .clk_rise   (clk_rise),
    .running    (running)
`ifdef FREQ_GEN_CYCLE_CNT_EN
    ,
    .cycle_count(cycle_count)
`endif
  );

  always #5 ref_clk = ~ref_clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rises[$];
  logic prev_rise = 1'b0;

  // Reference model: phase in [0,FULL), generating / stop-requested flags.
  int m_phase, m_act, m_pend;
  bit m_gen, m_stop, m_pend_v, m_out, m_rise;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_act = 0; m_pend = 0;
    m_gen = 0; m_stop = 0; m_pend_v = 0; m_out = 0; m_rise = 0;
  endtask

  // Advance the model by one ref_clk edge using the inputs currently applied.
  task automatic model_step();
    int sum;
    bit wrapped, next_gen, next_stop, accepted, upper_half, next_out;
    sum        = m_phase + m_act;
    wrapped    = m_gen && (sum >= FULL);
    accepted   = fcw_valid && !m_pend_v;
    next_gen   = m_gen;
    next_stop  = m_stop;
    if (!m_gen) begin
      next_gen = enable; next_stop = 0;
    end else if (enable) begin
      next_stop = 0;
    end else if (!m_stop) begin
      next_stop = 1;
    end else if (wrapped || m_act == 0) begin
      next_gen = 0; next_stop = 0;
    end
    // clk_out shows the upper half of the previous phase; no new pulse on stop.
    upper_half = (m_phase >= HALF);
    if (!next_gen && !m_out) next_out = 0;
    else next_out = upper_half;
    m_rise = next_out && !m_out;
    m_out  = next_out;
    if (!next_gen) m_phase = 0;
    else if (m_gen) m_phase = sum % FULL;
    if (accepted) begin
      m_pend   = (int'(fcw) > HALF) ? HALF : int'(fcw);
      m_pend_v = 1;
    end else if (m_pend_v && (!m_gen || wrapped)) begin
      m_act    = m_pend;
      m_pend_v = 0;
    end
    m_gen  = next_gen;
    m_stop = next_stop;
  endtask

  task automatic cycle();
    model_step();
    @(posedge ref_clk);
    #1;
    cyc++;
    check("clk_out",   32'(clk_out),   32'(m_out));
    check("clk_rise",  32'(clk_rise),  32'(m_rise));
    check("running",   32'(running),   32'(m_gen));
    check("fcw_ready", 32'(fcw_ready), 32'(!m_pend_v));
    check("rise_while_idle", 32'(clk_rise & ~running), 32'd0);
    check("rise_twice", 32'(clk_rise & prev_rise), 32'd0);
    prev_rise = clk_rise;
    if (clk_rise) rises.push_back(cyc);
  endtask

  // Hold an fcw offer until the handshake completes (bounded).
  task automatic offer(input logic [ACC_W-1:0] value);
    bit took;
    took      = 0;
    fcw       = value;
    fcw_valid = 1'b1;
    for (int i = 0; i < 600 && !took; i++) begin
      took = fcw_ready;
      cycle();
    end
    fcw_valid = 1'b0;
    check("offer_accepted", 32'(took), 32'd1);
  endtask

  // Asynchronous reset pulse between edges; outputs must react before any edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_clk_out",   32'(clk_out),   32'd0);
    check("rst_clk_rise",  32'(clk_rise),  32'd0);
    check("rst_running",   32'(running),   32'd0);
    check("rst_fcw_ready", 32'(fcw_ready), 32'd1);
`ifdef FREQ_GEN_CYCLE_CNT_EN
    check("rst_cycle_count", cycle_count, 32'd0);
`endif
    model_reset();
    prev_rise = 1'b0;
    @(negedge ref_clk);
    rst_n = 1'b1;
  endtask

  task automatic check_period(input string tag, input int exp);
    if (rises.size() < 3) check(tag, 32'(rises.size()), 32'd3);
    else check(tag, 32'(rises[$] - rises[$-1]), 32'(exp));
  endtask

  initial begin
    bit prev_level;
    model_reset();
    #1;
    do_reset();
    repeat (2) cycle();

    // fcw=64: period 4, two high and two low
    offer(8'd64);
    enable = 1'b1;
    rises.delete();
`ifdef FREQ_GEN_CYCLE_CNT_EN
    repeat (8) cycle();
    cnt_start = cycle_count;
    repeat (40) cycle();
    check("cycle_count_40", cycle_count - cnt_start, 32'd10);
`else
    repeat (30) cycle();
`endif
    check_period("period_64", 4);
    check("running_64", 32'(running), 32'd1);

    // retune to 32 mid-period: fcw_ready stays low until the wrap
    cycle();
    offer(8'd32);
    check("ready_low_after_offer", 32'(fcw_ready), 32'd0);
    rises.delete();
    repeat (40) cycle();
    check_period("period_32", 8);

    // 200 clamps to Nyquist: clk_out toggles every cycle
    offer(8'd200);
    repeat (20) cycle();
    for (int i = 0; i < 6; i++) begin
      prev_level = clk_out;
      cycle();
      check("nyquist_toggle", 32'(clk_out), 32'(!prev_level));
    end

    // graceful stop during a high phase
    offer(8'd64);
    repeat (20) cycle();
    for (int i = 0; i < 20 && !clk_out; i++) cycle();
    check("high_phase_found", 32'(clk_out), 32'd1);
    enable = 1'b0;
    for (int i = 0; i < 40 && running; i++) cycle();
    check("stopped", 32'(running), 32'd0);
    cycle();
    check("stop_clk_low", 32'(clk_out), 32'd0);
    check("stop_idle", 32'(running), 32'd0);

    // reset mid-run discards the pending fcw
    enable = 1'b1;
    repeat (12) cycle();
    fcw = 8'd32;
    fcw_valid = 1'b1;
    cycle();
    fcw_valid = 1'b0;
    do_reset();
    repeat (6) cycle();
    check("post_reset_flat", 32'(clk_out), 32'd0);
    enable = 1'b0;
    repeat (3) cycle();

    // random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) enable = ~enable;
      fcw_valid = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0:       fcw = 8'd0;
        1:       fcw = 8'd128;
        2:       fcw = 8'($urandom_range(129, 255));
        default: fcw = 8'($urandom_range(1, 127));
      endcase
      if ($urandom_range(0, 699) == 0) do_reset();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
